ram_loader: RTL
===============

# ram_loader

Sequential program loader sitting directly upstream of the 256×4 main memory in the SAP-style datapath. It accepts a stream of 4-bit nibbles over a valid/ready handshake and writes them to consecutive RAM addresses through the memory's manual-mode path. It generates the memory's edge-triggered write strobe with guaranteed address/data setup and hold. A run starts at a programmable base address and covers a programmable length; the address wraps from 255 to 0.

## Interface
- ADDR_W, 8, RAM address width
- DATA_W, 4, RAM data width
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a load run; ignored while busy
- base_addr  in  ADDR_W  first RAM address, sampled on accepted start
- length  in  ADDR_W+1  nibble count, sampled on accepted start; 0 means no writes; values >256 saturate to 256
- in_valid  in  1  upstream nibble valid
- in_data  in  DATA_W  upstream nibble
- in_ready  out  1  loader can accept a nibble this cycle
- address  out  ADDR_W  RAM address
- manual_mode  out  1  selects the manual_data path of the RAM
- manual_data  out  DATA_W  RAM write data
- w_enable  out  1  RAM write strobe; the RAM writes on its rising edge
- r_enable  out  1  RAM read enable; used only for verify
- rd_data  in  DATA_W  RAM read bus (wbus); used only for verify
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run
- error  out  1  sticky verify mismatch flag

## Operation
- States: IDLE, WAIT_DATA, SETUP, STROBE, RECOVER, VERIFY (macro only), DONE.
- IDLE: start=1 loads address←base_addr, remaining←sat(length), clears error, sets busy and manual_mode. Next state is WAIT_DATA, or DONE if length=0.
- WAIT_DATA: in_ready=1. On in_valid&in_ready, the loader latches in_data into manual_data and moves to SETUP.
- SETUP: w_enable=0; address and manual_data are stable.
- STROBE: w_enable=1 (registered, glitch-free).
- RECOVER: w_enable=0; address and data are held. Next state is VERIFY if compiled in. Otherwise the exit actions apply.
- Exit actions (leaving RECOVER or VERIFY): address←address+1 mod 256; remaining←remaining−1. Next state is DONE if remaining reaches 0, else WAIT_DATA.
- DONE: done=1 for one cycle, busy=0 and manual_mode=0 from the next cycle, then IDLE.
- manual_data and address stay at their last values after a run.
- The loader never drives wbus.
- Simultaneous start and busy: start is ignored. in_valid outside WAIT_DATA: not accepted, because in_ready=0.

## Timing
- Reset values: in_ready=0, address=0, manual_mode=0, manual_data=0, w_enable=0, r_enable=0, busy=0, done=0, error=0, state IDLE.
- Every output is a register, except in_ready, which is decoded from state.
- Write cost per nibble is 4 cycles without verify and 5 with verify, plus any upstream stall.
- Setup: address/data are stable at least 1 full cycle before the rising edge of w_enable.
- Hold: address/data are stable at least 1 full cycle after the falling edge of w_enable.
- The first w_enable rise occurs at the earliest 2 cycles after the accepting handshake.
- done follows the last RECOVER/VERIFY by 1 cycle. A length-0 run asserts done 1 cycle after start.
- Reset mid-run forces w_enable low asynchronously. This is a falling edge only, so no spurious write occurs. A strobe already high is abandoned, and no write is guaranteed for that nibble.

## Configuration
- LOADER_VERIFY_EN defined: the VERIFY state exists and runs after every write.
  - r_enable=1 during VERIFY.
  - rd_data is registered at the end of VERIFY and compared to manual_data.
  - A mismatch sets error, which stays set until the next accepted start. The run continues.
- LOADER_VERIFY_EN undefined: there is no VERIFY state. r_enable and error are tied to 0, and rd_data is unused.

## Structure
- Package ram_loader_pkg holds the state enum, ADDR_W/DATA_W defaults, and MAX_LEN=256.
- One sub-module, ram_loader_cnt, holds the address register (load, increment with wrap) and the remaining-count register (saturating load, decrement, zero flag).

## Test plan
- Basic run: base 0x10, length 3, nibbles 0xA,0x5,0xF with in_valid always high. Expect RAM[0x10..0x12] = A,5,F. Expect w_enable high exactly 3 single-cycle pulses, done 12 cycles after the first handshake, and busy then low.
- Wrap: base 0xFE, length 4, data 1,2,3,4. Expect RAM[0xFE]=1, [0xFF]=2, [0x00]=3, [0x01]=4, with final address 0x02.
- Stall and start: hold in_valid low 5 cycles between nibbles. Expect no w_enable rise during the stall and address/data unchanged. A start pulse during the run is ignored.
- Length 0 and length 300: length 0 gives done 1 cycle after start with no w_enable. Length 300 writes exactly 256 nibbles.
- Reset mid-run: assert rst_n low during STROBE of nibble 2 of 4. Expect all outputs at reset values immediately, nibble 1 intact, and no writes after reset.
- LOADER_VERIFY_EN: force rd_data=0x0 on the second write of 0x7. Expect error=1 after that VERIFY, still set at done, and cleared on the next start.

Source files
------------

// File: rtl/ram_loader_pkg.sv
// ============================================================================
// ram_loader_pkg : shared widths, length limit and loader state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package ram_loader_pkg;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 4;
    localparam int MAX_LEN = 256;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_DATA = 3'd1,
        ST_SETUP     = 3'd2,
        ST_STROBE    = 3'd3,
        ST_RECOVER   = 3'd4,
        ST_VERIFY    = 3'd5,
        ST_DONE      = 3'd6
    } state_e;

endpackage

`default_nettype wire

// File: rtl/ram_loader_cnt.sv
// ============================================================================
// ram_loader_cnt : RAM address register (load / wrap increment) and
//                  saturating remaining-nibble counter with last-item flag
// Rev 1.0
// ============================================================================
`default_nettype none

module ram_loader_cnt #(
    parameter int ADDR_W  = ram_loader_pkg::ADDR_W,
    parameter int LEN_MAX = ram_loader_pkg::MAX_LEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_step,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W:0]   i_length,
    output logic [ADDR_W-1:0] o_address,
    output logic              o_last
);
    import ram_loader_pkg::*;

    localparam logic [ADDR_W:0] C_LEN_MAX = (ADDR_W + 1)'(LEN_MAX);
    localparam logic [ADDR_W:0] C_ONE     = (ADDR_W + 1)'(1);

    logic [ADDR_W-1:0] address_q, address_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;

    always_comb begin
        address_d   = address_q;
        remaining_d = remaining_q;
        if (i_load) begin
            address_d   = i_base;
            remaining_d = (i_length > C_LEN_MAX) ? C_LEN_MAX : i_length;
        end else if (i_step) begin
            // address wraps naturally at the top of the RAM
            address_d   = address_q + 1'b1;
            remaining_d = (remaining_q == '0) ? '0 : remaining_q - C_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            address_q   <= '0;
            remaining_q <= '0;
        end else begin
            address_q   <= address_d;
            remaining_q <= remaining_d;
        end
    end

    assign o_address = address_q;
    assign o_last    = (remaining_q == C_ONE);

endmodule

`default_nettype wire

// File: rtl/ram_loader.sv
// ============================================================================
// ram_loader : streams nibbles into consecutive RAM addresses with a
//              registered write strobe; optional read-back via LOADER_VERIFY_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module ram_loader #(
    parameter int ADDR_W = ram_loader_pkg::ADDR_W,
    parameter int DATA_W = ram_loader_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] address,
    output logic              manual_mode,
    output logic [DATA_W-1:0] manual_data,
    output logic              w_enable,
    output logic              r_enable,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              error
);
    import ram_loader_pkg::*;

    state_e            state_q, state_d;
    logic              busy_q, busy_d;
    logic              manual_mode_q, manual_mode_d;
    logic [DATA_W-1:0] manual_data_q, manual_data_d;
    logic              w_enable_q, w_enable_d;
    logic              r_enable_q, r_enable_d;
    logic              done_q, done_d;
    logic              w_cnt_load, w_cnt_step, w_cnt_last;
    state_e            w_exit_state;

    ram_loader_cnt #(
        .ADDR_W  (ADDR_W),
        .LEN_MAX (1 << ADDR_W)
    ) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_cnt_load),
        .i_step    (w_cnt_step),
        .i_base    (base_addr),
        .i_length  (length),
        .o_address (address),
        .o_last    (w_cnt_last)
    );

    assign w_exit_state = w_cnt_last ? ST_DONE : ST_WAIT_DATA;

`ifdef LOADER_VERIFY_EN
    logic error_q, error_d;
`else
    logic unused_rd_data;
    assign unused_rd_data = ^rd_data;
`endif

    always_comb begin
        state_d       = state_q;
        busy_d        = busy_q;
        manual_mode_d = manual_mode_q;
        manual_data_d = manual_data_q;
        w_cnt_load    = 1'b0;
        w_cnt_step    = 1'b0;
`ifdef LOADER_VERIFY_EN
        error_d       = error_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    w_cnt_load    = 1'b1;
                    busy_d        = 1'b1;
                    manual_mode_d = 1'b1;
`ifdef LOADER_VERIFY_EN
                    error_d       = 1'b0;
`endif
                    state_d       = (length == '0) ? ST_DONE : ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                if (in_valid) begin
                    manual_data_d = in_data;
                    state_d       = ST_SETUP;
                end
            end
            ST_SETUP:  state_d = ST_STROBE;
            ST_STROBE: state_d = ST_RECOVER;
            ST_RECOVER: begin
`ifdef LOADER_VERIFY_EN
                state_d = ST_VERIFY;
`else
                w_cnt_step = 1'b1;
                state_d    = w_exit_state;
`endif
            end
`ifdef LOADER_VERIFY_EN
            ST_VERIFY: begin
                // read-back mismatch is sticky; the run carries on regardless
                if (rd_data != manual_data_q) begin
                    error_d = 1'b1;
                end
                w_cnt_step = 1'b1;
                state_d    = w_exit_state;
            end
`endif
            ST_DONE: begin
                busy_d        = 1'b0;
                manual_mode_d = 1'b0;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // strobes are decoded from the next state so they leave a flop cleanly
    assign w_enable_d = (state_d == ST_STROBE);
    assign r_enable_d = (state_d == ST_VERIFY);
    assign done_d     = (state_d == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            busy_q        <= 1'b0;
            manual_mode_q <= 1'b0;
            manual_data_q <= '0;
            w_enable_q    <= 1'b0;
            r_enable_q    <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            manual_mode_q <= manual_mode_d;
            manual_data_q <= manual_data_d;
            w_enable_q    <= w_enable_d;
            r_enable_q    <= r_enable_d;
            done_q        <= done_d;
        end
    end

`ifdef LOADER_VERIFY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    assign in_ready    = (state_q == ST_WAIT_DATA);
    assign busy        = busy_q;
    assign manual_mode = manual_mode_q;
    assign manual_data = manual_data_q;
    assign w_enable    = w_enable_q;
    assign r_enable    = r_enable_q;
    assign done        = done_q;

endmodule

`default_nettype wire
